// File: rtl/node_pkg.sv
// node_pkg: shared state encoding and default data width for the mu-search node
package node_pkg;
  localparam int DEF_W = 16;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CHECK} state_t;
endpackage

// File: rtl/node_mu_search_starter.sv
// starter: rising-edge detector on a level start request, gated by an enable
module starter (
  input  logic CLK,
  input  logic RST,
  input  logic i_st,
  input  logic i_en,
  output logic o_go
);
  logic r_prev;
  // remember last ST level; tracking continues while busy so a held ST never retriggers
  always_ff @(posedge CLK) r_prev <= RST ? 1'b0 : i_st;
  assign o_go = i_st & ~r_prev & i_en;
endmodule

// File: rtl/node_mu_search.sv
// node_mu_search: mu-operator, finds the smallest y with f(x,y)==0 using a child node for f
// Optional MU_TIMEOUT_EN bounds the search at MAX_ITER and flags ERR with RES all ones.
module node_mu_search
  import node_pkg::*;
#(
  parameter int          W        = DEF_W,
  parameter logic [15:0] MAX_ITER = 16'd1000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  input  logic [W-1:0] IN0,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         ERR,
  output logic         CH_ST,
  output logic [W-1:0] CH_IN0,
  output logic [W-1:0] CH_IN1,
  input  logic         CH_RD,
  input  logic [W-1:0] CH_RES
);
  state_t       r_state, w_next;
  logic [W-1:0] r_x, r_y, r_res;
  logic         r_err, r_ch_prev, r_zero, w_go, w_tmo;
  starter u_starter (.CLK(CLK), .RST(RST), .i_st(ST), .i_en(r_state == IDLE), .o_go(w_go));
`ifdef MU_TIMEOUT_EN
  assign w_tmo = (r_y == W'(MAX_ITER));
`else
  logic w_unused_max;
  assign w_unused_max = |MAX_ITER;
  assign w_tmo = 1'b0;
`endif
  // next-state: launch child, wait for it to go busy, then for its 0->1 done edge, then judge
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_go ? LAUNCH : IDLE;
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = CH_RD ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: w_next = (CH_RD && !r_ch_prev) ? CHECK : WAIT_DONE;
      CHECK:     w_next = (r_zero || w_tmo) ? IDLE : LAUNCH;
      default:   w_next = IDLE;
    endcase
  end
  // state register and datapath; RES only changes on a finished search
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_res     <= '0;
      r_err     <= 1'b0;
      r_ch_prev <= 1'b1;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ch_prev <= CH_RD;
      if (r_state == IDLE && w_go) begin
        r_x   <= IN0;
        r_y   <= '0;
        r_err <= 1'b0;
      end
      if (r_state == WAIT_DONE && w_next == CHECK) r_zero <= (CH_RES == '0);
      if (r_state == CHECK) begin
        if (r_zero) r_res <= r_y;
        else if (w_tmo) begin
          r_res <= '1;
          r_err <= 1'b1;
        end else r_y <= r_y + 1'b1;
      end
    end
  end
  assign RD     = (r_state == IDLE);
  assign RES    = r_res;
  assign ERR    = r_err;
  assign CH_ST  = (r_state == LAUNCH);
  assign CH_IN0 = r_x;
  assign CH_IN1 = r_y;
endmodule

// File: tb/tb_node_mu_search.sv
// tb_node_mu_search: directed tests of the mu-search node against a monus child model
module tb_node_mu_search;
  localparam int W = 16;
  logic         CLK = 0, RST = 1, ST = 0, RD, ERR, CH_ST, CH_RD;
  logic [W-1:0] IN0 = '0, RES, CH_IN0, CH_IN1, CH_RES;
  int checks = 0, errors = 0;
  int npulse = 0, seq_err = 0, stab_viol = 0;
  logic [W-1:0] last_y;
  bit rand_lat = 0, const1 = 0;
  int cnt = 0;
  logic [W-1:0] ax, ay, prev_in1;

  node_mu_search #(.W(W), .MAX_ITER(16'd8)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .RD(RD), .RES(RES), .ERR(ERR),
    .CH_ST(CH_ST), .CH_IN0(CH_IN0), .CH_IN1(CH_IN1), .CH_RD(CH_RD), .CH_RES(CH_RES));

  always #5 CLK = ~CLK;

  // child: f(x,y)=monus(x,y), latency 3 or random 1..20
  always @(posedge CLK) begin
    if (RST) begin
      CH_RD <= 1'b1; CH_RES <= '0; cnt <= 0;
    end else if (CH_ST) begin
      CH_RD <= 1'b0; ax <= CH_IN0; ay <= CH_IN1;
      cnt <= rand_lat ? int'($urandom_range(1, 20)) : 3;
    end else if (!CH_RD) begin
      if (cnt <= 1) begin
        CH_RD  <= 1'b1;
        CH_RES <= const1 ? W'(1) : (ax > ay ? ax - ay : '0);
      end else cnt <= cnt - 1;
    end
  end

  // pulse counter, y-sequence and stability monitor
  always @(posedge CLK) begin
    if (CH_ST) begin
      if (CH_IN1 !== W'(npulse)) seq_err++;
      last_y = CH_IN1;
      npulse++;
    end
    if (!RST && !CH_RD && CH_IN1 !== prev_in1) stab_viol++;
    prev_in1 = CH_IN1;
  end

  task automatic start(input logic [W-1:0] x);
    @(negedge CLK);
    npulse = 0; seq_err = 0; stab_viol = 0;
    IN0 = x; ST = 1;
    @(negedge CLK);
    ST = 0;
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!RD && n < 3000) begin @(negedge CLK); n++; end
    if (!RD) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for RD, got RD=%b required 1", name, RD);
    end
  endtask

  task automatic test_reset;
    RST = 1;
    repeat (3) @(negedge CLK);
    checks += 6;
    if (RD !== 1'b1) begin errors++; $display("FAIL reset_rd got %b required 1", RD); end
    if (RES !== '0) begin errors++; $display("FAIL reset_res got %h required 0", RES); end
    if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", ERR); end
    if (CH_ST !== 1'b0) begin errors++; $display("FAIL reset_chst got %b required 0", CH_ST); end
    if (CH_IN0 !== '0) begin errors++; $display("FAIL reset_chin0 got %h required 0", CH_IN0); end
    if (CH_IN1 !== '0) begin errors++; $display("FAIL reset_chin1 got %h required 0", CH_IN1); end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    start(16'd5);
    checks++;
    if (RD !== 1'b0) begin errors++; $display("FAIL basic_busy got RD=%b required 0", RD); end
    wait_rd("basic");
    checks += 5;
    if (npulse != 6) begin errors++; $display("FAIL basic_pulses got %0d required 6", npulse); end
    if (seq_err != 0) begin errors++; $display("FAIL basic_yseq got %0d bad required 0", seq_err); end
    if (RES !== 16'd5) begin errors++; $display("FAIL basic_res got %0d required 5", RES); end
    if (ERR !== 1'b0) begin errors++; $display("FAIL basic_err got %b required 0", ERR); end
    if (CH_IN0 !== 16'd5) begin errors++; $display("FAIL basic_chin0 got %0d required 5", CH_IN0); end
  endtask

  task automatic test_zero;
    start(16'd0);
    wait_rd("zero");
    checks += 3;
    if (npulse != 1) begin errors++; $display("FAIL zero_pulses got %0d required 1", npulse); end
    if (last_y !== '0) begin errors++; $display("FAIL zero_y got %0d required 0", last_y); end
    if (RES !== '0) begin errors++; $display("FAIL zero_res got %0d required 0", RES); end
  endtask

  task automatic test_busy_ignore;
    start(16'd3);
    repeat (4) @(negedge CLK);
    IN0 = 16'd9; ST = 1;
    @(negedge CLK);
    ST = 0;
    wait_rd("busy_ignore");
    checks += 2;
    if (RES !== 16'd3) begin errors++; $display("FAIL busy_res got %0d required 3", RES); end
    if (npulse != 4) begin errors++; $display("FAIL busy_pulses got %0d required 4", npulse); end
  endtask

  task automatic test_held;
    @(negedge CLK);
    npulse = 0; seq_err = 0;
    IN0 = 16'd2; ST = 1;
    repeat (100) @(negedge CLK);
    checks += 3;
    if (npulse != 3) begin errors++; $display("FAIL held_pulses got %0d required 3", npulse); end
    if (RES !== 16'd2) begin errors++; $display("FAIL held_res got %0d required 2", RES); end
    if (RD !== 1'b1) begin errors++; $display("FAIL held_rd got %b required 1", RD); end
    ST = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    start(16'd7);
    while (npulse < 4 && n < 500) begin @(negedge CLK); n++; end
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    checks += 4;
    if (npulse != 4) begin errors++; $display("FAIL mid_reach got %0d pulses required 4", npulse); end
    if (RD !== 1'b1) begin errors++; $display("FAIL mid_rd got %b required 1", RD); end
    if (RES !== '0) begin errors++; $display("FAIL mid_res got %0d required 0", RES); end
    if (CH_ST !== 1'b0) begin errors++; $display("FAIL mid_chst got %b required 0", CH_ST); end
    RST = 0;
    @(negedge CLK);
    start(16'd1);
    wait_rd("mid_restart");
    checks++;
    if (RES !== 16'd1) begin errors++; $display("FAIL mid_restart_res got %0d required 1", RES); end
  endtask

  task automatic test_random_latency;
    rand_lat = 1;
    start(16'd4);
    wait_rd("random");
    checks += 3;
    if (RES !== 16'd4) begin errors++; $display("FAIL rand_res got %0d required 4", RES); end
    if (stab_viol != 0) begin errors++; $display("FAIL rand_stable got %0d changes required 0", stab_viol); end
    if (npulse != 5) begin errors++; $display("FAIL rand_pulses got %0d required 5", npulse); end
    rand_lat = 0;
  endtask

`ifdef MU_TIMEOUT_EN
  task automatic test_timeout;
    const1 = 1;
    start(16'd3);
    wait_rd("timeout");
    checks += 4;
    if (npulse != 9) begin errors++; $display("FAIL tmo_pulses got %0d required 9", npulse); end
    if (RES !== 16'hFFFF) begin errors++; $display("FAIL tmo_res got %h required ffff", RES); end
    if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_err got %b required 1", ERR); end
    if (RD !== 1'b1) begin errors++; $display("FAIL tmo_rd got %b required 1", RD); end
    const1 = 0;
    start(16'd1);
    wait_rd("tmo_clear");
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL tmo_clear_err got %b required 0", ERR); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_busy_ignore;
    test_held;
    test_reset_mid;
    test_random_latency;
`ifdef MU_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
